// File: rtl/masked_share_split.sv
// Arithmetic-masking front end: splits P and H into two additive shares mod MODULUS
// and runs the engine start/done handshake. Optional share self-check: MASK_SHARE_CHECK_EN.
module masked_share_split #(
  parameter int RADIX   = 13,
  parameter int MODULUS = 8191
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADIX-1:0]   P,
  input  logic [RADIX-1:0]   H,
  input  logic [2*RADIX-1:0] rnd,
  input  logic               rnd_valid,
  output logic               rnd_req,
  output logic [RADIX-1:0]   P1,
  output logic [RADIX-1:0]   P2,
  output logic [RADIX-1:0]   H1,
  output logic [RADIX-1:0]   H2,
  output logic               arith_start,
  input  logic               arith_done,
  output logic               out_done,
  output logic               mask_err,
  output logic [2:0]         dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both 1
  // (in_valid/in_ready for P/H, rnd_valid/rnd_req for the TRNG word); valid must be
  // held by the source until it is taken, and ready never depends on valid.

  localparam logic [RADIX-1:0] Q = RADIX'(MODULUS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAW    = 3'd1,
    S_SPLIT   = 3'd2,
    S_START   = 3'd3,
    S_RUN     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  function automatic logic [RADIX-1:0] reduce_once(input logic [RADIX-1:0] v);
    return (v >= Q) ? v - Q : v;
  endfunction

  // a - b mod q for a, b < q: borrow bit selects the +q correction.
  function automatic logic [RADIX-1:0] sub_mod(input logic [RADIX-1:0] a,
                                              input logic [RADIX-1:0] b);
    logic [RADIX:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[RADIX]) d = d + {1'b0, Q};
    return d[RADIX-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [RADIX-1:0] p_q, h_q, r1_q, r2_q;
  logic [RADIX-1:0] p1_q, p2_q, h1_q, h2_q;

  logic [RADIX-1:0] r1_w, r2_w;
  logic             rnd_ok;
  logic             load_ph, load_rnd, do_split, clr;

  assign r1_w   = rnd[RADIX-1:0];
  assign r2_w   = rnd[2*RADIX-1:RADIX];
  // Any out-of-range half discards the whole word so both shares stay uniform.
  assign rnd_ok = (r1_w < Q) && (r2_w < Q);

`ifdef MASK_SHARE_CHECK_EN
  function automatic logic [RADIX-1:0] add_mod(input logic [RADIX-1:0] a,
                                              input logic [RADIX-1:0] b);
    logic [RADIX:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[RADIX-1:0];
  endfunction

  logic chk_bad, set_err, mask_err_q;
  assign chk_bad = (add_mod(p1_q, p2_q) != p_q) || (add_mod(h1_q, h2_q) != h_q);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)       mask_err_q <= 1'b0;
    else if (set_err) mask_err_q <= 1'b1;
  end
  assign mask_err = mask_err_q;
`else
  assign mask_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    rnd_req     = 1'b0;
    arith_start = 1'b0;
    out_done    = 1'b0;
    load_ph     = 1'b0;
    load_rnd    = 1'b0;
    do_split    = 1'b0;
    clr         = 1'b0;
`ifdef MASK_SHARE_CHECK_EN
    set_err     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_ph = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        rnd_req = 1'b1;
        if (rnd_valid && rnd_ok) begin
          load_rnd = 1'b1;
          state_d  = S_SPLIT;
        end
      end
      S_SPLIT: begin
        do_split = 1'b1;
        state_d  = S_START;
      end
      S_START: begin
`ifdef MASK_SHARE_CHECK_EN
        if (chk_bad) begin
          set_err = 1'b1;
          clr     = 1'b1;
          state_d = S_IDLE;
        end else begin
`else
        begin
`endif
          arith_start = 1'b1;
          if (!arith_done) state_d = S_RUN;
        end
      end
      S_RUN: begin
        arith_start = 1'b1;
        if (arith_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        out_done = 1'b1;
        clr      = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      h_q     <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_ph) begin
        p_q <= reduce_once(P);
        h_q <= reduce_once(H);
      end
      if (load_rnd) begin
        r1_q <= r1_w;
        r2_q <= r2_w;
      end
      if (do_split) begin
        p1_q <= r1_q;
        p2_q <= sub_mod(p_q, r1_q);
        h1_q <= r2_q;
        h2_q <= sub_mod(h_q, r2_q);
      end
      // Scrub the plain secret and randomness once the engine has consumed the shares.
      if (clr) begin
        p_q  <= '0;
        h_q  <= '0;
        r1_q <= '0;
        r2_q <= '0;
      end
    end
  end

  assign P1        = p1_q;
  assign P2        = p2_q;
  assign H1        = h1_q;
  assign H2        = h2_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_masked_share_split.sv
// Bench for masked_share_split: random requests, TRNG rejections and engine timing,
// with a queue scoreboard checked by an independent monitor on out_done.
module tb_masked_share_split;

  localparam int R = 13;
  localparam int Q = 8191;

  logic          clock, rst_n;
  logic          in_valid, in_ready;
  logic [R-1:0]  P, H;
  logic [2*R-1:0] rnd;
  logic          rnd_valid, rnd_req;
  logic [R-1:0]  P1, P2, H1, H2;
  logic          arith_start, arith_done, out_done, mask_err;
  logic [2:0]    dbg_state;

  masked_share_split #(.RADIX(R), .MODULUS(Q)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .H(H), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_req(rnd_req),
    .P1(P1), .P2(P2), .H1(H1), .H2(H2), .arith_start(arith_start),
    .arith_done(arith_done), .out_done(out_done), .mask_err(mask_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  logic [4*R-1:0] exp_q[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, exp_done = 0;
  bit in_rst_test = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic on integers.
  function automatic logic [4*R-1:0] model(input int p, input int h, input int r1, input int r2);
    int pr, hr, p2, h2;
    pr = p % Q;
    hr = h % Q;
    p2 = (pr - r1 + Q) % Q;
    h2 = (hr - r2 + Q) % Q;
    return {R'(r1), R'(p2), R'(r2), R'(h2)};
  endfunction

  // ---------------- engine model ----------------
  int eng_h1 = 2, eng_h0 = 5;
  int eng_ph = 0, eng_cnt = 0;
  initial begin
    arith_done = 1'b1;
    forever begin
      @(negedge clock);
      if (!arith_start) begin
        eng_ph     = 0;
        arith_done = 1'b1;
      end else begin
        case (eng_ph)
          0: begin
            eng_cnt = eng_h1;
            eng_ph  = 1;
            if (eng_cnt == 0) begin
              arith_done = 1'b0;
              eng_cnt    = eng_h0;
              eng_ph     = 2;
            end
          end
          1: begin
            eng_cnt--;
            if (eng_cnt <= 0) begin
              arith_done = 1'b0;
              eng_cnt    = eng_h0;
              eng_ph     = 2;
            end
          end
          2: begin
            eng_cnt--;
            if (eng_cnt <= 0) begin
              arith_done = 1'b1;
              eng_ph     = 3;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic           prev_start, chk_ready_next;
    logic [4*R-1:0] e;
    prev_start     = 1'b0;
    chk_ready_next = 1'b0;
    forever begin
      @(negedge clock);
      if (chk_ready_next) check("ready_after_done", in_ready, 1);
      chk_ready_next = 1'b0;
      if (prev_start && !arith_start && !in_rst_test)
        check("start_held_to_done", out_done, 1);
      if (out_done) begin
        done_cnt++;
        chk_ready_next = 1'b1;
        check("ready_low_in_release", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("P1", P1, e[4*R-1:3*R]);
          check("P2", P2, e[3*R-1:2*R]);
          check("H1", H1, e[2*R-1:R]);
          check("H2", H2, e[R-1:0]);
        end
      end
      prev_start = arith_start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic do_req(input int p, input int h, input int r1, input int r2,
                        input int nrej, input bit lat, input bit push);
    logic [R-1:0] a, b;
    wait_ready();
    in_valid = 1'b1;
    P        = R'(p);
    H        = R'(h);
    a        = R'(r1);
    b        = R'(r2);
    if (lat) begin
      rnd       = {b, a};
      rnd_valid = 1'b1;
    end else begin
      rnd_valid = 1'b0;
    end
    if (push) begin
      exp_q.push_back(model(p, h, r1, r2));
      exp_done++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("ready_low_after_accept", in_ready, 0);
    check("rnd_req_in_draw", rnd_req, 1);
    if (lat) begin
      @(negedge clock);
      rnd_valid = 1'b0;
      check("lat_split_no_start", arith_start, 0);
      check("lat_split_no_req", rnd_req, 0);
      @(negedge clock);
      check("lat_start_at_3", arith_start, 1);
    end else begin
      for (int i = 0; i < nrej; i++) begin
        if ($urandom_range(0, 1) == 0) rnd = {R'($urandom_range(0, Q - 1)), R'(Q)};
        else                           rnd = {R'(Q), R'($urandom_range(0, Q - 1))};
        rnd_valid = 1'b1;
        @(negedge clock);
        check("rnd_req_held_after_reject", rnd_req, 1);
        if ($urandom_range(0, 1) == 1) begin
          rnd_valid = 1'b0;
          @(negedge clock);
          check("rnd_req_held_in_gap", rnd_req, 1);
        end
      end
      rnd       = {b, a};
      rnd_valid = 1'b1;
      @(negedge clock);
      rnd_valid = 1'b0;
      check("rnd_req_drop_after_accept", rnd_req, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    P         = '0;
    H         = '0;
    rnd       = '0;
    rnd_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_rnd_req", rnd_req, 0);
    check("rst_start", arith_start, 0);
    check("rst_out_done", out_done, 0);
    check("rst_mask_err", mask_err, 0);
    check("rst_shares", {P1, P2, H1, H2}, 0);
    rst_n = 1'b1;

    eng_h1 = 2; eng_h0 = 5;
    do_req(100, 50, 30, 7, 0, 1, 1);
    eng_h1 = 1; eng_h0 = 2;
    do_req(5, 0, 8000, 1, 0, 0, 1);
    do_req(1234, 4321, 10, 20, 1, 0, 1);
    do_req(777, 8190, 777, 8190, 0, 1, 1);
    do_req(0, 0, 0, 0, 0, 0, 1);
    do_req(8191, 8191, 55, 66, 2, 0, 1);

    for (int i = 0; i < 20; i++) begin
      int nr;
      bit lt;
      eng_h1 = $urandom_range(0, 3);
      eng_h0 = $urandom_range(1, 6);
      nr     = $urandom_range(0, 2);
      lt     = (nr == 0) && ($urandom_range(0, 1) == 1);
      do_req($urandom_range(0, Q), $urandom_range(0, Q),
             $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), nr, lt, 1);
    end

    // Reset while the engine is busy, then a clean request.
    eng_h1 = 0; eng_h0 = 60;
    do_req(4000, 3000, 123, 456, 0, 0, 1);
    n = 0;
    while (!(arith_start && !arith_done) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("reach_busy_before_reset", arith_start && !arith_done, 1);
    @(negedge clock);
    in_rst_test = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_start", arith_start, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_shares", {P1, P2, H1, H2}, 0);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_done--;
    end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    in_rst_test = 1'b0;
    eng_h1 = 2; eng_h0 = 3;
    do_req(100, 50, 30, 7, 0, 1, 1);

`ifdef MASK_SHARE_CHECK_EN
    begin
      bit saw_start = 1'b0;
      wait_ready();
      force dut.p2_q = 13'd1;
      do_req(100, 50, 30, 7, 0, 0, 0);
      n = 0;
      while (!in_ready && n < 50) begin
        if (arith_start) saw_start = 1'b1;
        @(negedge clock);
        n++;
      end
      check("chk_mask_err", mask_err, 1);
      check("chk_no_start", saw_start, 0);
      check("chk_back_idle", in_ready, 1);
      release dut.p2_q;
    end
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("out_done_count", done_cnt, exp_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
